// File: rtl/maze_pkg.sv
// Shared MAZE mesh definitions: packet layout, link directions and common widths.
// Used by the port arbiter and by the test environment.
package maze_pkg;

    localparam int PKT_W = 23;
    localparam int IDX_W = 3;

    // Packet fields, MSB first: [22:21] type, [20] qos, [19:14] src, [13:8] tgt, [7:0] data.
    typedef struct packed {
        logic [1:0] ptype;
        logic       qos;
        logic [5:0] src;
        logic [5:0] tgt;
        logic [7:0] data;
    } pkt_t;

    typedef enum logic [2:0] {
        DIR_N = 3'd0,
        DIR_W = 3'd1,
        DIR_S = 3'd2,
        DIR_E = 3'd3,
        DIR_L = 3'd4
    } dir_e;

endpackage

// File: rtl/maze_rr_pick.sv
// Combinational masked round-robin picker: the first set request strictly after
// ptr wins, with the search wrapping from NREQ-1 back to 0.
module maze_rr_pick
    import maze_pkg::*;
#(
    parameter int NREQ = 5
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int cand;
        // NOTE: every output gets a default before the search loop; otherwise a
        // path with no match would infer a latch.
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        // Search from the farthest offset down, so the nearest candidate overwrites last.
        for (int off = NREQ; off >= 1; off--) begin
            cand = (int'(ptr) + off) % NREQ;
            if (req[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/maze_port_arb.sv
// Output-port arbiter for one MAZE node link: QoS-aware round-robin with an age-based
// starvation escape, feeding a single valid/ready pipeline register.
module maze_port_arb
    import maze_pkg::*;
#(
    parameter int NREQ    = 5,
    parameter int PKT_W   = maze_pkg::PKT_W,
    parameter int AGE_MAX = 15,
    parameter int AGE_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_vld,
    input  logic [NREQ*PKT_W-1:0] req_pkt,
    output logic [NREQ-1:0]       req_rdy,
    output logic                  out_vld,
    output logic [PKT_W-1:0]      out_pkt,
    output logic [IDX_W-1:0]      out_src,
    input  logic                  out_rdy,
    output logic [NREQ-1:0]       aged_flag
);

    localparam int QOS_BIT = PKT_W - 3;

    logic [AGE_W-1:0] wait_cnt [NREQ];
    logic [IDX_W-1:0] rr_ptr;
    logic [NREQ-1:0]  qos_vec;
    logic [NREQ-1:0]  cls2, cls1, cls0, sel_mask;
    logic [NREQ-1:0]  grant_oh;
    logic [IDX_W-1:0] grant_idx;
    logic             pick_any;
    logic             ld;
    logic             grant_fire;

    always_comb begin
        qos_vec = '0;
        for (int i = 0; i < NREQ; i++) begin
            qos_vec[i] = req_pkt[i*PKT_W + QOS_BIT];
        end
    end

    always_comb begin
        aged_flag = '0;
        for (int i = 0; i < NREQ; i++) begin
            aged_flag[i] = (wait_cnt[i] == AGE_W'(AGE_MAX));
        end
    end

    // Only the highest non-empty class reaches the picker; the pointer is shared.
    assign cls2     = aged_flag & req_vld;
    assign cls1     = req_vld & qos_vec;
    assign cls0     = req_vld & ~qos_vec;
    assign sel_mask = (|cls2) ? cls2 : ((|cls1) ? cls1 : cls0);

    maze_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req   (sel_mask),
        .ptr   (rr_ptr),
        .grant (grant_oh),
        .idx   (grant_idx),
        .any   (pick_any)
    );

    assign ld         = !out_vld || out_rdy;
    assign grant_fire = ld && pick_any;
    assign req_rdy    = grant_fire ? grant_oh : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            out_pkt <= '0;
            out_src <= '0;
            rr_ptr  <= IDX_W'(NREQ - 1);
        end else if (ld) begin
            out_vld <= grant_fire;
            if (grant_fire) begin
                out_pkt <= req_pkt[int'(grant_idx)*PKT_W +: PKT_W];
                out_src <= grant_idx;
                rr_ptr  <= grant_idx;
            end
        end
    end

    // NOTE: the wait counters are reset element by element; aged_flag is decoded from
    // them, so leaving this small array unreset would let X reach the grant logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_vld[i] || req_rdy[i]) begin
                    wait_cnt[i] <= '0;
                end else if (ld && (wait_cnt[i] != AGE_W'(AGE_MAX))) begin
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule
